// File: rtl/tthbif_pkg.sv
// Shared types and helpers for the tthbif delay line.
package tthbif_pkg;

    typedef enum logic [0:0] {
        CFG_IDLE  = 1'b0,
        CFG_APPLY = 1'b1
    } cfg_state_e;

    // Index width that stays at least one bit for single-entry ranges.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tthbif_delay_chan.sv
// One delay channel: DEPTH-stage shift chain with a tap-selected output.
module tthbif_delay_chan
    import tthbif_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       en_i,
    input  logic                       flush_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic [$clog2(DEPTH)-1:0]   tap_i,
    output logic [WIDTH-1:0]           data_o
);

    localparam int unsigned TW = $clog2(DEPTH);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
            stage_d[k] = stage_q[k];
        end
        if (flush_i) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                stage_d[k] = '0;
            end
        end else if (en_i) begin
            stage_d[0] = data_i;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                stage_d[k] = stage_q[k-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    // Tap mux; unreachable tap codes on non-power-of-two depths read as zero.
    always_comb begin
        data_o = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (tap_i == TW'(k)) begin
                data_o = stage_q[k];
            end
        end
    end

endmodule

// File: rtl/tthbif_delay_line.sv
// Multi-channel programmable delay line with shared fill tracking and tap config port.
module tthbif_delay_line
    import tthbif_pkg::*;
#(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned NUM_CH = 2
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic                                         en_i,
    input  logic                                         flush_i,
    input  logic [NUM_CH*WIDTH-1:0]                      data_i,
    output logic [NUM_CH*WIDTH-1:0]                      data_o,
    output logic [NUM_CH-1:0]                            valid_o,
    input  logic                                         cfg_valid_i,
    output logic                                         cfg_ready_o,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch_i,
    input  logic [$clog2(DEPTH)-1:0]                     cfg_tap_i,
    output logic                                         cfg_err_o
);

    localparam int unsigned TW = $clog2(DEPTH);
    localparam int unsigned CW = idx_width(NUM_CH);
    localparam int unsigned FW = $clog2(DEPTH + 1);

    logic [TW-1:0] tap_q [NUM_CH];
    logic [TW-1:0] tap_d [NUM_CH];
    logic [FW-1:0] fill_q;
    logic [FW-1:0] fill_d;
    cfg_state_e    state_q;
    cfg_state_e    state_d;
    logic          cfg_err_q;
    logic          cfg_err_d;
    logic          req_in_range;

    // Widened compares so the range check stays meaningful for any DEPTH/NUM_CH.
    assign req_in_range = ({1'b0, cfg_tap_i} < (TW+1)'(DEPTH)) &&
                          ({1'b0, cfg_ch_i}  < (CW+1)'(NUM_CH));

    // Fill counter: saturates at DEPTH, cleared by flush.
    always_comb begin
        fill_d = fill_q;
        if (flush_i) begin
            fill_d = '0;
        end else if (en_i && (fill_q != FW'(DEPTH))) begin
            fill_d = fill_q + FW'(1);
        end
    end

    // Config FSM next state, tap writes and error pulse.
    always_comb begin
        state_d   = state_q;
        cfg_err_d = 1'b0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            tap_d[c] = tap_q[c];
        end
        case (state_q)
            CFG_IDLE: begin
                if (cfg_valid_i) begin
                    if (req_in_range) begin
                        for (int unsigned c = 0; c < NUM_CH; c++) begin
                            if (cfg_ch_i == CW'(c)) begin
                                tap_d[c] = cfg_tap_i;
                            end
                        end
                        state_d = CFG_APPLY;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            CFG_APPLY: begin
                state_d = CFG_IDLE;
            end
            default: begin
                state_d = CFG_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= CFG_IDLE;
            cfg_err_q <= 1'b0;
            fill_q    <= '0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                tap_q[c] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cfg_err_q <= cfg_err_d;
            fill_q    <= fill_d;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                tap_q[c] <= tap_d[c];
            end
        end
    end

    assign cfg_ready_o = (state_q == CFG_IDLE);
    assign cfg_err_o   = cfg_err_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        tthbif_delay_chan #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_chan (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .en_i    (en_i),
            .flush_i (flush_i),
            .data_i  (data_i[c*WIDTH +: WIDTH]),
            .tap_i   (tap_q[c]),
            .data_o  (data_o[c*WIDTH +: WIDTH])
        );

        // A lane is valid once enough samples have entered to reach its tap.
        assign valid_o[c] = (fill_q > FW'(tap_q[c]));
    end

endmodule

// File: tb/tb_tthbif_delay_line.sv
// Directed bench: 4-bit x 8-deep x 2-channel instance plus a 6-deep x 3-channel instance for range errors.
module tb_tthbif_delay_line;

    logic clk;
    logic rst;

    logic       en_a, flush_a, cfgv_a, rdy_a, err_a;
    logic [7:0] data_a, dout_a;
    logic [1:0] valid_a;
    logic [0:0] ch_a;
    logic [2:0] tap_a;

    logic        en_b, flush_b, cfgv_b, rdy_b, err_b;
    logic [11:0] data_b, dout_b;
    logic [2:0]  valid_b;
    logic [1:0]  ch_b;
    logic [2:0]  tap_b;

    int errors = 0;
    int checks = 0;

    tthbif_delay_line #(.WIDTH(4), .DEPTH(8), .NUM_CH(2)) u_dut_a (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en_a),
        .flush_i     (flush_a),
        .data_i      (data_a),
        .data_o      (dout_a),
        .valid_o     (valid_a),
        .cfg_valid_i (cfgv_a),
        .cfg_ready_o (rdy_a),
        .cfg_ch_i    (ch_a),
        .cfg_tap_i   (tap_a),
        .cfg_err_o   (err_a)
    );

    tthbif_delay_line #(.WIDTH(4), .DEPTH(6), .NUM_CH(3)) u_dut_b (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en_b),
        .flush_i     (flush_b),
        .data_i      (data_b),
        .data_o      (dout_b),
        .valid_o     (valid_b),
        .cfg_valid_i (cfgv_b),
        .cfg_ready_o (rdy_b),
        .cfg_ch_i    (ch_b),
        .cfg_tap_i   (tap_b),
        .cfg_err_o   (err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_a(input logic [0:0] ch, input logic [2:0] tap);
        cfgv_a = 1'b1;
        ch_a   = ch;
        tap_a  = tap;
        step();
        cfgv_a = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++; if (dout_a !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", dout_a); end
        checks++; if (valid_a !== 2'b00) begin errors++; $display("FAIL reset_valid got=%b exp=00", valid_a); end
        checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", rdy_a); end
        checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err_a); end
        checks++; if (rdy_b !== 1'b1) begin errors++; $display("FAIL reset_ready_b got=%b exp=1", rdy_b); end
    endtask

    task automatic test_stream();
        logic [3:0] exp1;
        cfg_a(1'b1, 3'd7);
        en_a = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            data_a = {4'(i), 4'(i)};
            step();
            exp1 = (i >= 8) ? 4'(i - 7) : 4'd0;
            checks++; if (dout_a[3:0] !== 4'(i)) begin errors++; $display("FAIL stream_ch0 i=%0d got=%h exp=%h", i, dout_a[3:0], 4'(i)); end
            checks++; if (valid_a[0] !== 1'b1) begin errors++; $display("FAIL stream_v0 i=%0d got=%b exp=1", i, valid_a[0]); end
            checks++; if (valid_a[1] !== (i >= 8)) begin errors++; $display("FAIL stream_v1 i=%0d got=%b exp=%b", i, valid_a[1], (i >= 8)); end
            checks++; if (dout_a[7:4] !== exp1) begin errors++; $display("FAIL stream_ch1 i=%0d got=%h exp=%h", i, dout_a[7:4], exp1); end
        end
        en_a = 1'b0;
    endtask

    task automatic test_enable();
        logic       en_seq [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [3:0] din    [6] = '{4'd5, 4'd9, 4'd6, 4'd9, 4'd7, 4'd9};
        logic       exp_v  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [3:0] exp_d  [6] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd5, 4'd5};
        flush_a = 1'b1;
        step();
        flush_a = 1'b0;
        cfg_a(1'b0, 3'd2);
        for (int i = 0; i < 6; i++) begin
            en_a   = en_seq[i];
            data_a = {4'd0, din[i]};
            step();
            checks++; if (valid_a[0] !== exp_v[i]) begin errors++; $display("FAIL enable_v0 step=%0d got=%b exp=%b", i, valid_a[0], exp_v[i]); end
            checks++; if (dout_a[3:0] !== exp_d[i]) begin errors++; $display("FAIL enable_ch0 step=%0d got=%h exp=%h", i, dout_a[3:0], exp_d[i]); end
        end
        en_a = 1'b0;
    endtask

    task automatic test_cfg_apply();
        flush_a = 1'b1;
        step();
        flush_a = 1'b0;
        en_a = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            data_a = {4'(i), 4'(i)};
            step();
        end
        checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL apply_ready_pre got=%b exp=1", rdy_a); end
        cfgv_a = 1'b1; ch_a = 1'b1; tap_a = 3'd3;
        data_a = 8'h66;
        step();
        checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL apply_ready_low got=%b exp=0", rdy_a); end
        checks++; if (dout_a[7:4] !== 4'd3) begin errors++; $display("FAIL apply_ch1_new_tap got=%h exp=3", dout_a[7:4]); end
        checks++; if (valid_a[1] !== 1'b1) begin errors++; $display("FAIL apply_v1 got=%b exp=1", valid_a[1]); end
        tap_a  = 3'd0;
        data_a = 8'h77;
        step();
        cfgv_a = 1'b0;
        checks++; if (dout_a[7:4] !== 4'd4) begin errors++; $display("FAIL apply_drop_second got=%h exp=4", dout_a[7:4]); end
        checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL apply_ready_back got=%b exp=1", rdy_a); end
        checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL apply_no_err got=%b exp=0", err_a); end
        en_a = 1'b0;
    endtask

    task automatic test_flush();
        logic [1:0] exp_v [4] = '{2'b00, 2'b00, 2'b01, 2'b11};
        logic [7:0] exp_d [4] = '{8'h00, 8'h00, 8'h01, 8'h12};
        en_a = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            data_a = {4'(i), 4'(i)};
            step();
        end
        checks++; if (valid_a !== 2'b11) begin errors++; $display("FAIL flush_prefill_valid got=%b exp=11", valid_a); end
        flush_a = 1'b1;
        data_a  = 8'hff;
        step();
        flush_a = 1'b0;
        checks++; if (dout_a !== 8'h00) begin errors++; $display("FAIL flush_data got=%h exp=00", dout_a); end
        checks++; if (valid_a !== 2'b00) begin errors++; $display("FAIL flush_valid got=%b exp=00", valid_a); end
        for (int k = 0; k < 4; k++) begin
            data_a = {4'(k + 1), 4'(k + 1)};
            step();
            checks++; if (valid_a !== exp_v[k]) begin errors++; $display("FAIL refill_valid k=%0d got=%b exp=%b", k + 1, valid_a, exp_v[k]); end
            checks++; if (dout_a !== exp_d[k]) begin errors++; $display("FAIL refill_data k=%0d got=%h exp=%h", k + 1, dout_a, exp_d[k]); end
        end
        en_a = 1'b0;
    endtask

    task automatic test_cfg_err();
        cfgv_b = 1'b1; ch_b = 2'd0; tap_b = 3'd1;
        step();
        cfgv_b = 1'b0;
        step();
        cfgv_b = 1'b1; ch_b = 2'd0; tap_b = 3'd6;
        step();
        cfgv_b = 1'b0;
        checks++; if (err_b !== 1'b1) begin errors++; $display("FAIL err_tap_pulse got=%b exp=1", err_b); end
        checks++; if (rdy_b !== 1'b1) begin errors++; $display("FAIL err_tap_ready got=%b exp=1", rdy_b); end
        step();
        checks++; if (err_b !== 1'b0) begin errors++; $display("FAIL err_tap_clear got=%b exp=0", err_b); end
        cfgv_b = 1'b1; ch_b = 2'd3; tap_b = 3'd2;
        step();
        cfgv_b = 1'b0;
        checks++; if (err_b !== 1'b1) begin errors++; $display("FAIL err_ch_pulse got=%b exp=1", err_b); end
        checks++; if (rdy_b !== 1'b1) begin errors++; $display("FAIL err_ch_ready got=%b exp=1", rdy_b); end
        step();
        checks++; if (err_b !== 1'b0) begin errors++; $display("FAIL err_ch_clear got=%b exp=0", err_b); end
        en_b = 1'b1;
        data_b = 12'h001;
        step();
        data_b = 12'h002;
        step();
        en_b = 1'b0;
        checks++; if (dout_b !== 12'h001) begin errors++; $display("FAIL err_tap_kept got=%h exp=001", dout_b); end
        checks++; if (valid_b !== 3'b111) begin errors++; $display("FAIL err_valid_b got=%b exp=111", valid_b); end
    endtask

    task automatic test_reset_apply();
        cfgv_a = 1'b1; ch_a = 1'b0; tap_a = 3'd5;
        step();
        checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL rstapply_in_apply got=%b exp=0", rdy_a); end
        rst = 1'b1; en_a = 1'b1; data_a = 8'h99;
        step();
        rst = 1'b0; cfgv_a = 1'b0; en_a = 1'b0;
        checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL rstapply_ready got=%b exp=1", rdy_a); end
        checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL rstapply_err got=%b exp=0", err_a); end
        checks++; if (dout_a !== 8'h00) begin errors++; $display("FAIL rstapply_data got=%h exp=00", dout_a); end
        checks++; if (valid_a !== 2'b00) begin errors++; $display("FAIL rstapply_valid got=%b exp=00", valid_a); end
        en_a = 1'b1; data_a = 8'h43;
        step();
        en_a = 1'b0;
        checks++; if (dout_a !== 8'h43) begin errors++; $display("FAIL rstapply_taps_zero got=%h exp=43", dout_a); end
        checks++; if (valid_a !== 2'b11) begin errors++; $display("FAIL rstapply_valid_after got=%b exp=11", valid_a); end
    endtask

    initial begin
        rst = 1'b1;
        en_a = 1'b0; flush_a = 1'b0; data_a = '0; cfgv_a = 1'b0; ch_a = '0; tap_a = '0;
        en_b = 1'b0; flush_b = 1'b0; data_b = '0; cfgv_b = 1'b0; ch_b = '0; tap_b = '0;
        test_reset();
        test_cfg_err();
        test_stream();
        test_enable();
        test_cfg_apply();
        test_flush();
        test_reset_apply();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
